itype_detector_mp: RTL and testbench
====================================

Name: itype_detector_mp

Overview:
- Multi-retire successor of the single-port instruction-type classifier in the CVA6 trace-encoder connector.
- Classifies up to NRET committed instructions per cycle into E-trace itype codes. Supports ITYPE_LEN 2, 3 or 4, including call, return and co-routine detection in 4-bit mode.
- Holds interrupts that arrive without a commit (sticky) until they can be attached to an emitted beat.
- Sits between the CVA6 commit/scoreboard taps and the trace-encoder packet filter, behind a registered ready/valid output stage with a one-entry skid buffer.

Parameters:
- NRET, 2, number of commit ports classified per cycle (1..4).
- ITYPE_LEN, 3, itype field width (2, 3 or 4); selects the encoding mode.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- valid_i  in  NRET  per-port instruction committed.
- exception_i  in  NRET  per-port exception on that slot.
- interrupt_i  in  1  interrupt taken this cycle (commit not required).
- op_i  in  NRET x mure_pkg::fu_op  per-port functional-unit op.
- is_jal_i  in  NRET  per-port direct jump (JAL or C.J/C.JAL).
- branch_taken_i  in  NRET  per-port branch resolution.
- rd_i  in  NRET x 5  per-port destination register.
- rs1_i  in  NRET x 5  per-port source register 1.
- ready_o  out  1  beat accepted this cycle.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts the beat.
- iretire_o  out  NRET  per-port valid of the output beat.
- itype_o  out  NRET x ITYPE_LEN  per-port itype.

Behaviour:
- Classification is combinational per port; first match wins:
  - EXC: exception.
  - INT: interrupt attached to this port.
  - ERET: MRET/SRET/DRET.
  - NTB: not-taken branch.
  - TB: taken branch.
  - ITYPE_LEN 3: JALR gives UIJ=6; everything else is STD.
  - ITYPE_LEN 4, link register = x1 or x5:
    - JALR with rd link, rs1 link and rd!=rs1: co-routine swap = 12.
    - JALR with rd link: uninferable call = 8.
    - JALR with rs1 link and rd not link: return = 13.
    - Other JALR: uninferable jump = 10.
    - JAL with rd link: inferable call = 9.
    - Other JAL: inferable jump = 11.
  - ITYPE_LEN 2: only STD, EXC, INT, ERET are produced; branch and jump classes map to STD.
- Interrupt attach:
  - An effective interrupt (interrupt_i | irq_pending_q) attaches to the lowest-index valid port of an accepted beat.
  - If no port is valid, or ready_o=0, set irq_pending_q.
  - irq_pending_q clears on the cycle the interrupt is attached.
  - An interrupt arriving while already pending is merged (still one pending).
- Beat accepted when ready_o=1 and (|valid_i or an interrupt attach is possible).
  - An interrupt with no valid port produces no beat; it only pends.
- Output stage:
  - Latency is 1 cycle: an accepted beat appears at valid_o on the next edge.
  - Output register holds the beat while valid_o=1 and ready_i=0.
  - A beat accepted during that stall goes to the skid register.
  - ready_o = skid register empty.
  - Occupancy runs 0..2. On ready_i the skid entry moves to the output register in the same cycle it drains.
  - Order is preserved; no beat is dropped or duplicated.
- Simultaneous accept and drain at occupancy 1: the output register is replaced by the new beat; occupancy stays 1.
- Reset (any cycle, including mid-stall): valid_o=0, iretire_o=0, itype_o=0 (STD), skid empty, irq_pending_q=0, ready_o=1 on the first cycle after reset. In-flight beats are discarded.
- iretire_o and itype_o are held stable while valid_o=1 and ready_i=0.

Decomposition:
- mure_pkg gains:
  - itype_e extended to 4-bit values (UCALL=8, ICALL=9, UJ4=10, IJ=11, COSWAP=12, RET=13).
  - LINK_X1=1 and LINK_X5=5.
  - An is_link() function.
  - A packed itype_beat_t {iretire, itype[NRET]} struct.
- One sub-module, itype_classify_port: the combinational single-port classifier, instantiated NRET times.
- The sticky interrupt logic and skid buffer live in the top.

Test Plan:
- ITYPE_LEN=3, port0 BRANCH taken, port1 JALR, ready_i=1 → next cycle valid_o=1, itype_o={6,5}, iretire_o=2'b11.
- ITYPE_LEN=4 single-port JALR cases:
  - rd=1, rs1=5 → 12.
  - rd=1, rs1=2 → 8.
  - rd=0, rs1=1 → 13.
  - JAL rd=5 → 9.
  - JAL rd=0 → 11.
- interrupt_i=1 with valid_i=0, then valid_i=2'b10 two cycles later → no beat first; then beat itype_o[1]=INT(2), irq_pending_q cleared.
- Backpressure: ready_i=0 for 3 cycles with a beat every cycle → ready_o falls after the 2nd accept; after ready_i=1, beats emerge in order and none are lost.
- port0 exception plus interrupt_i same cycle → port0=EXC(1). The interrupt attaches to port0 only if port0 has no exception; otherwise it goes to the next valid port, or pends if none.
- rst_i asserted mid-stall with occupancy 2 → next cycle valid_o=0, ready_o=1, pending interrupt cleared.

Source files
------------

// File: rtl/mure_pkg.sv
// Shared types for the multi-retire trace connector: functional-unit ops,
// E-trace itype codes and link-register helpers.
package mure_pkg;

    typedef enum logic [3:0] {
        ADD    = 4'd0,
        SUB    = 4'd1,
        LOAD   = 4'd2,
        STORE  = 4'd3,
        EQ     = 4'd4,
        NE     = 4'd5,
        LTS    = 4'd6,
        LTU    = 4'd7,
        GES    = 4'd8,
        GEU    = 4'd9,
        JALR   = 4'd10,
        MRET   = 4'd11,
        SRET   = 4'd12,
        DRET   = 4'd13,
        CSR_OP = 4'd14,
        FENCE  = 4'd15
    } fu_op;

    // Codes 8..13 only exist in the 4-bit encoding.
    typedef enum logic [3:0] {
        IT_STD    = 4'd0,
        IT_EXC    = 4'd1,
        IT_INT    = 4'd2,
        IT_ERET   = 4'd3,
        IT_NTB    = 4'd4,
        IT_TB     = 4'd5,
        IT_UIJ    = 4'd6,
        IT_RSVD   = 4'd7,
        IT_UCALL  = 4'd8,
        IT_ICALL  = 4'd9,
        IT_UJ4    = 4'd10,
        IT_IJ     = 4'd11,
        IT_COSWAP = 4'd12,
        IT_RET    = 4'd13
    } itype_e;

    localparam int unsigned NRET_MAX = 4;
    localparam logic [4:0]  LINK_X1  = 5'd1;
    localparam logic [4:0]  LINK_X5  = 5'd5;

    // Widest beat format, for consumers that handle any NRET/ITYPE_LEN.
    typedef struct packed {
        logic [NRET_MAX-1:0]        iretire;
        logic [NRET_MAX-1:0][3:0]   itype;
    } itype_beat_t;

    function automatic logic is_link(input logic [4:0] r);
        return (r == LINK_X1) || (r == LINK_X5);
    endfunction

    function automatic logic is_branch(input fu_op op);
        return (op == EQ) || (op == NE) || (op == LTS) ||
               (op == LTU) || (op == GES) || (op == GEU);
    endfunction

endpackage

// File: rtl/itype_classify_port.sv
// Combinational itype classifier for one commit port; first matching rule wins.
module itype_classify_port
    import mure_pkg::*;
#(
    parameter int unsigned ITYPE_LEN = 3
) (
    input  logic                 valid,
    input  logic                 exception,
    input  logic                 irq,
    input  fu_op                 op,
    input  logic                 is_jal,
    input  logic                 branch_taken,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    output logic [ITYPE_LEN-1:0] itype
);

    itype_e code;

    always_comb begin
        code = IT_STD;
        if (!valid) begin
            code = IT_STD;
        end else if (exception) begin
            code = IT_EXC;
        end else if (irq) begin
            code = IT_INT;
        end else if (op == MRET || op == SRET || op == DRET) begin
            code = IT_ERET;
        end else if (is_branch(op)) begin
            code = branch_taken ? IT_TB : IT_NTB;
        end else if (ITYPE_LEN == 3) begin
            code = (op == JALR) ? IT_UIJ : IT_STD;
        end else if (ITYPE_LEN == 4) begin
            if (op == JALR) begin
                if (is_link(rd) && is_link(rs1) && rd != rs1) code = IT_COSWAP;
                else if (is_link(rd))                         code = IT_UCALL;
                else if (is_link(rs1))                        code = IT_RET;
                else                                          code = IT_UJ4;
            end else if (is_jal) begin
                code = is_link(rd) ? IT_ICALL : IT_IJ;
            end
        end
        // 2-bit mode has no room for branch/jump classes.
        if (ITYPE_LEN == 2 && code > IT_ERET) code = IT_STD;
    end

    assign itype = ITYPE_LEN'(code);

endmodule

// File: rtl/itype_detector_mp.sv
// Multi-retire itype detector: per-port classification, sticky interrupt
// attach and a registered ready/valid output with a one-entry skid buffer.
module itype_detector_mp
    import mure_pkg::*;
#(
    parameter int unsigned NRET      = 2,
    parameter int unsigned ITYPE_LEN = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NRET-1:0]                valid_i,
    input  logic [NRET-1:0]                exception_i,
    input  logic                           interrupt_i,
    input  fu_op [NRET-1:0]                op_i,
    input  logic [NRET-1:0]                is_jal_i,
    input  logic [NRET-1:0]                branch_taken_i,
    input  logic [NRET-1:0][4:0]           rd_i,
    input  logic [NRET-1:0][4:0]           rs1_i,
    output logic                           ready_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [NRET-1:0]                iretire_o,
    output logic [NRET-1:0][ITYPE_LEN-1:0] itype_o
);

    typedef struct packed {
        logic [NRET-1:0]                iretire;
        logic [NRET-1:0][ITYPE_LEN-1:0] itype;
    } beat_t;

    logic                           irq_pending_q;
    logic                           irq_eff;
    logic                           irq_attach;
    logic                           cand_found;
    logic [NRET-1:0]                irq_cand;
    logic [NRET-1:0]                irq_sel;
    logic                           accept;
    logic [NRET-1:0][ITYPE_LEN-1:0] itype_w;
    beat_t                          beat_new;

    logic                           out_valid_q;
    beat_t                          out_q;
    logic                           skid_valid_q;
    beat_t                          skid_q;

    // An interrupt rides on the lowest valid slot that is not already an exception.
    always_comb begin
        irq_cand   = '0;
        cand_found = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            if (valid_i[i] && !exception_i[i] && !cand_found) begin
                irq_cand[i] = 1'b1;
                cand_found  = 1'b1;
            end
        end
    end

    assign ready_o    = !skid_valid_q;
    assign accept     = ready_o && (|valid_i);
    assign irq_eff    = interrupt_i || irq_pending_q;
    assign irq_attach = irq_eff && ready_o && cand_found;
    assign irq_sel    = irq_attach ? irq_cand : '0;

    for (genvar g = 0; g < NRET; g++) begin : g_port
        itype_classify_port #(
            .ITYPE_LEN(ITYPE_LEN)
        ) u_classify (
            .valid       (valid_i[g]),
            .exception   (exception_i[g]),
            .irq         (irq_sel[g]),
            .op          (op_i[g]),
            .is_jal      (is_jal_i[g]),
            .branch_taken(branch_taken_i[g]),
            .rd          (rd_i[g]),
            .rs1         (rs1_i[g]),
            .itype       (itype_w[g])
        );
    end

    assign beat_new.iretire = valid_i;
    assign beat_new.itype   = itype_w;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_pending_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_q         <= '0;
            skid_valid_q  <= 1'b0;
            skid_q        <= '0;
        end else begin
            if (irq_attach) begin
                irq_pending_q <= 1'b0;
            end else if (irq_eff) begin
                irq_pending_q <= 1'b1;
            end

            // Output register free or draining: refill from skid first to keep order.
            if (!out_valid_q || ready_i) begin
                if (skid_valid_q) begin
                    out_q        <= skid_q;
                    skid_valid_q <= 1'b0;
                end else if (accept) begin
                    out_q       <= beat_new;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (accept) begin
                skid_q       <= beat_new;
                skid_valid_q <= 1'b1;
            end
        end
    end

    assign valid_o   = out_valid_q;
    assign iretire_o = out_q.iretire;
    assign itype_o   = out_q.itype;

endmodule

// File: tb/tb_itype_detector_mp.sv
// Directed bench for itype_detector_mp: three instances (ITYPE_LEN 2/3/4)
// share the same stimulus; expected values are hand-computed constants.
module tb_itype_detector_mp;
    import mure_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      valid;
    logic [1:0]      exc;
    logic            irq;
    fu_op [1:0]      op;
    logic [1:0]      is_jal;
    logic [1:0]      taken;
    logic [1:0][4:0] rd;
    logic [1:0][4:0] rs1;
    logic            ready_in;

    logic            ready2, ready3, ready4;
    logic            valid2, valid3, valid4;
    logic [1:0]      iret2, iret3, iret4;
    logic [1:0][1:0] itype2;
    logic [1:0][2:0] itype3;
    logic [1:0][3:0] itype4;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    itype_detector_mp #(.NRET(2), .ITYPE_LEN(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .exception_i(exc),
        .interrupt_i(irq), .op_i(op), .is_jal_i(is_jal), .branch_taken_i(taken),
        .rd_i(rd), .rs1_i(rs1), .ready_o(ready2), .valid_o(valid2),
        .ready_i(ready_in), .iretire_o(iret2), .itype_o(itype2));

    itype_detector_mp #(.NRET(2), .ITYPE_LEN(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .exception_i(exc),
        .interrupt_i(irq), .op_i(op), .is_jal_i(is_jal), .branch_taken_i(taken),
        .rd_i(rd), .rs1_i(rs1), .ready_o(ready3), .valid_o(valid3),
        .ready_i(ready_in), .iretire_o(iret3), .itype_o(itype3));

    itype_detector_mp #(.NRET(2), .ITYPE_LEN(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .exception_i(exc),
        .interrupt_i(irq), .op_i(op), .is_jal_i(is_jal), .branch_taken_i(taken),
        .rd_i(rd), .rs1_i(rs1), .ready_o(ready4), .valid_o(valid4),
        .ready_i(ready_in), .iretire_o(iret4), .itype_o(itype4));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        valid  = '0;
        exc    = '0;
        irq    = 1'b0;
        op[0]  = ADD;
        op[1]  = ADD;
        is_jal = '0;
        taken  = '0;
        rd     = '0;
        rs1    = '0;
    endtask

    // Single-port 4-bit jump table: op, is_jal, rd, rs1, itype(4), itype(3).
    fu_op       j_op  [5] = '{JALR, JALR, JALR, ADD, ADD};
    logic       j_jal [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0] j_rd  [5] = '{5'd1, 5'd1, 5'd0, 5'd5, 5'd0};
    logic [4:0] j_rs1 [5] = '{5'd5, 5'd2, 5'd1, 5'd0, 5'd0};
    int         j_e4  [5] = '{12, 8, 13, 9, 11};
    int         j_e3  [5] = '{6, 6, 6, 0, 0};

    initial begin
        rst      = 1'b1;
        ready_in = 1'b1;
        clear_in();
        tick();
        tick();
        check_val("rst_valid", 32'(valid3), 32'd0);
        check_val("rst_ready", 32'(ready3), 32'd1);
        check_val("rst_iret", 32'(iret3), 32'd0);
        check_val("rst_itype", 32'(itype3), 32'd0);
        rst = 1'b0;
        tick();

        // Taken branch on port0, JALR (non-link) on port1.
        valid = 2'b11; op[0] = EQ; taken[0] = 1'b1; op[1] = JALR; rs1[1] = 5'd2;
        tick();
        check_val("br_jalr_valid3", 32'(valid3), 32'd1);
        check_val("br_jalr_iret3", 32'(iret3), 32'd3);
        check_val("br_jalr_itype3", 32'(itype3), 32'h35);   // {6,5}
        check_val("br_jalr_itype4", 32'(itype4), 32'hA5);   // {10,5}
        check_val("br_jalr_itype2", 32'(itype2), 32'd0);
        clear_in();
        tick();
        check_val("drain_valid3", 32'(valid3), 32'd0);

        // ERET on port1, not-taken branch on port0.
        valid = 2'b11; op[0] = NE; op[1] = MRET;
        tick();
        check_val("eret_ntb_itype3", 32'(itype3), 32'h1C);  // {3,4}
        check_val("eret_ntb_itype2", 32'(itype2), 32'hC);   // {3,0}
        clear_in();

        for (int k = 0; k < 5; k++) begin
            valid = 2'b01; op[0] = j_op[k]; is_jal[0] = j_jal[k];
            rd[0] = j_rd[k]; rs1[0] = j_rs1[k];
            tick();
            check_val($sformatf("jump%0d_itype4", k), 32'(itype4[0]), 32'(j_e4[k]));
            check_val($sformatf("jump%0d_itype3", k), 32'(itype3[0]), 32'(j_e3[k]));
            clear_in();
        end
        tick();

        // Interrupt with no commit pends, then rides on the next valid slot.
        irq = 1'b1;
        tick();
        check_val("irq_nobeat", 32'(valid3), 32'd0);
        irq = 1'b0;
        tick();
        check_val("irq_nobeat2", 32'(valid3), 32'd0);
        valid = 2'b10;
        tick();
        check_val("irq_attach_valid", 32'(valid3), 32'd1);
        check_val("irq_attach_iret", 32'(iret3), 32'd2);
        check_val("irq_attach_itype", 32'(itype3), 32'h10);  // {2,0}
        tick();
        check_val("irq_cleared", 32'(itype3), 32'h00);
        clear_in();

        // Exception on port0 with interrupt: interrupt moves to port1.
        valid = 2'b11; exc = 2'b01; irq = 1'b1;
        tick();
        check_val("exc_irq_itype", 32'(itype3), 32'h11);     // {2,1}
        // Exception on the only valid slot: interrupt pends.
        valid = 2'b01; exc = 2'b01; irq = 1'b1;
        tick();
        check_val("exc_only_itype", 32'(itype3), 32'h01);
        clear_in();
        valid = 2'b01;
        tick();
        check_val("exc_pend_attach", 32'(itype3), 32'h02);
        valid = 2'b11; irq = 1'b1;
        tick();
        check_val("irq_port0", 32'(itype3), 32'h02);         // {0,2}
        clear_in();
        tick();

        // Backpressure: A,B accepted under stall, C held by ready_o low, then D.
        ready_in = 1'b0;
        valid = 2'b01; op[0] = EQ; taken[0] = 1'b1;                  // A
        tick();
        check_val("bp_a_valid", 32'(valid3), 32'd1);
        check_val("bp_a_ready", 32'(ready3), 32'd1);
        clear_in(); valid = 2'b01; op[0] = EQ;                       // B
        tick();
        check_val("bp_b_ready", 32'(ready3), 32'd0);
        check_val("bp_b_hold", 32'(itype3), 32'h05);
        clear_in(); valid = 2'b10; op[1] = MRET;                     // C
        tick();
        check_val("bp_c_ready", 32'(ready3), 32'd0);
        check_val("bp_c_hold", 32'(itype3), 32'h05);
        check_val("bp_c_holdret", 32'(iret3), 32'd1);
        ready_in = 1'b1;
        tick();
        check_val("bp_out_b", 32'(itype3), 32'h04);
        check_val("bp_out_b_ready", 32'(ready3), 32'd1);
        tick();
        check_val("bp_out_c", 32'(itype3), 32'h18);
        check_val("bp_out_c_iret", 32'(iret3), 32'd2);
        clear_in(); valid = 2'b11; op[1] = JALR;                     // D
        tick();
        check_val("bp_out_d", 32'(itype3), 32'h30);
        check_val("bp_out_d_valid", 32'(valid3), 32'd1);
        clear_in();
        tick();
        check_val("bp_empty", 32'(valid3), 32'd0);

        // Reset mid-stall with occupancy 2 and an interrupt pending.
        ready_in = 1'b0;
        valid = 2'b01; op[0] = EQ; taken[0] = 1'b1;
        tick();
        tick();
        check_val("rs_full", 32'(ready3), 32'd0);
        clear_in(); irq = 1'b1;
        tick();
        irq = 1'b0;
        rst = 1'b1;
        tick();
        check_val("rs_valid", 32'(valid3), 32'd0);
        check_val("rs_ready", 32'(ready3), 32'd1);
        check_val("rs_itype", 32'(itype3), 32'd0);
        check_val("rs_iret", 32'(iret3), 32'd0);
        rst = 1'b0;
        ready_in = 1'b1;
        valid = 2'b01;
        tick();
        check_val("rs_no_irq", 32'(itype3), 32'd0);
        check_val("rs_new_valid", 32'(valid3), 32'd1);
        clear_in();
        tick();
        check_val("rs_no_stale", 32'(valid3), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
